// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, falling-edge clocked; define UART_RX_MAJORITY_EN for 2-of-3 bit voting
module uart_rx #(
  parameter int CLKS_PER_BIT = 435,
  parameter int N = 9
) (
  input  logic       i_Clock,
  input  logic       rst,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Frame_Err
);
  localparam logic [N-1:0] H  = N'((CLKS_PER_BIT - 1) / 2);
  localparam logic [N-1:0] C1 = N'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q, sync_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d, byte_q, byte_d;
  logic dv_q, dv_d, err_q, err_d, active_q, active_d;
  logic s, bit_v;
  assign s = sync_q[1];
  assign sync_d = {sync_q[0], i_Rx_Serial};
`ifdef UART_RX_MAJORITY_EN
  localparam logic [N-1:0] C2 = N'(CLKS_PER_BIT - 2);
  localparam logic [N-1:0] C3 = N'(CLKS_PER_BIT - 3);
  logic [1:0] v_q, v_d;
  always_comb v_d = (state_q == DATA || state_q == STOP) ?
                    (cnt_q == C3 ? {v_q[1], s} : cnt_q == C2 ? {s, v_q[0]} : v_q) : v_q;
  assign bit_v = (v_q[0] & v_q[1]) | (v_q[0] & s) | (v_q[1] & s);
  always_ff @(negedge i_Clock)
    if (rst) v_q <= 2'b00;
    else v_q <= v_d;
`else
  assign bit_v = s;
`endif
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    dv_d     = 1'b0;
    err_d    = 1'b0;
    active_d = active_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!s) begin
          active_d = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        if (cnt_q == H) begin
          cnt_d = '0;
          if (s) begin
            active_d = 1'b0;
            state_d  = IDLE;
          end else state_d = DATA;
        end else cnt_d = cnt_q + N'(1);
      end
      DATA: begin
        if (cnt_q == C1) begin
          cnt_d = '0;
          shift_d[idx_q] = bit_v;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else cnt_d = cnt_q + N'(1);
      end
      STOP: begin
        if (cnt_q == C1) begin
          cnt_d    = '0;
          active_d = 1'b0;
          state_d  = CLEANUP;
          if (bit_v) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
          end else err_d = 1'b1;
        end else cnt_d = cnt_q + N'(1);
      end
      CLEANUP: if (s) state_d = IDLE;
      default: begin
        active_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end
  always_ff @(negedge i_Clock)
    if (rst) begin
      sync_q   <= 2'b11;
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      dv_q     <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      dv_q     <= dv_d;
      err_q    <= err_d;
      active_q <= active_d;
    end
  assign o_Rx_DV     = dv_q;
  assign o_Rx_Byte   = byte_q;
  assign o_Rx_Active = active_q;
  assign o_Frame_Err = err_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed table-driven bench for uart_rx at 8 clocks per bit
module tb_uart_rx;
  logic clk = 1'b0, rst = 1'b1, line = 1'b1;
  logic dv, err, active;
  logic [7:0] rx_byte;
  int cyc = 0, n_chk = 0, n_fail = 0, overlap = 0, fall_cyc = 0;
  int dv_cyc_q[$], err_cyc_q[$], rise_q[$];
  logic [7:0] dv_byte_q[$];
  bit act_prev = 1'b0;

  uart_rx #(.CLKS_PER_BIT(8), .N(4)) dut (
    .i_Clock(clk), .rst(rst), .i_Rx_Serial(line),
    .o_Rx_DV(dv), .o_Rx_Byte(rx_byte), .o_Rx_Active(active), .o_Frame_Err(err));

  always #5 clk = ~clk;
  always @(negedge clk) cyc <= cyc + 1;

  // outputs change on the falling edge, so observe them on the rising edge
  always @(posedge clk) begin
    if (dv === 1'b1) begin
      dv_cyc_q.push_back(cyc);
      dv_byte_q.push_back(rx_byte);
    end
    if (err === 1'b1) err_cyc_q.push_back(cyc);
    if (dv === 1'b1 && err === 1'b1) overlap++;
    if (active === 1'b1 && !act_prev) rise_q.push_back(cyc);
    if (active !== 1'b1 && act_prev) fall_cyc = cyc;
    act_prev = (active === 1'b1);
  end

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // drives len cycles of an 8N1 frame; line is sampled at edge t0+i+1 for step i
  task automatic send(input logic [7:0] d, input logic stop, input int glitch,
                      input int rst_at, input int len, output int t0);
    logic v;
    t0 = cyc;
    for (int i = 0; i < len; i++) begin
      v = (i < 8) ? 1'b0 : (i < 72) ? d[(i - 8) / 8] : stop;
      if (i == glitch) v = ~v;
      line = v;
      rst = (i == rst_at);
      @(posedge clk);
    end
    line = 1'b1;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    line = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  function automatic int dvb(input int k);
    return (k < dv_byte_q.size()) ? int'(dv_byte_q[k]) : -1;
  endfunction
  function automatic int dvc(input int k);
    return (k < dv_cyc_q.size()) ? dv_cyc_q[k] : -1;
  endfunction
  function automatic int erc(input int k);
    return (k < err_cyc_q.size()) ? err_cyc_q[k] : -1;
  endfunction

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic [7:0] exp_byte;
    int         n_dv;
    int         n_err;
  } vec_t;
  vec_t tv[6];

  initial begin
    int t0, t1, mdv, merr, mr, lat;
    logic [7:0] exp_maj;
    tv[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
    tv[1] = '{8'h3C, 1'b0, 8'hA5, 0, 1};
    tv[2] = '{8'h00, 1'b1, 8'h00, 1, 0};
    tv[3] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
    tv[4] = '{8'h3C, 1'b0, 8'hFF, 0, 1};
    tv[5] = '{8'h81, 1'b1, 8'h81, 1, 0};
    repeat (3) @(posedge clk);
    rst = 1'b0;
    @(posedge clk);
    check("reset_byte", rx_byte, 0);
    check("reset_dv", dv, 0);
    check("reset_active", active, 0);
    check("reset_err", err, 0);
    idle(4);

    for (int k = 0; k < 6; k++) begin
      mdv = dv_cyc_q.size();
      merr = err_cyc_q.size();
      mr = rise_q.size();
      send(tv[k].d, tv[k].stop, -1, -1, 80, t0);
      idle(16);
      check($sformatf("vec%0d_dv_count", k), dv_cyc_q.size() - mdv, tv[k].n_dv);
      check($sformatf("vec%0d_err_count", k), err_cyc_q.size() - merr, tv[k].n_err);
      check($sformatf("vec%0d_byte", k), rx_byte, tv[k].exp_byte);
      lat = (tv[k].n_dv != 0) ? dvc(mdv) - t0 : erc(merr) - t0;
      check($sformatf("vec%0d_strobe_edge", k), lat, 79);
      if (k == 0) begin
        check("vec0_active_rise", (rise_q.size() > mr) ? rise_q[mr] - t0 : -1, 3);
        check("vec0_active_fall", fall_cyc - t0, 79);
      end
    end

    mdv = dv_cyc_q.size();
    merr = err_cyc_q.size();
    send(8'h00, 1'b1, -1, -1, 80, t0);
    send(8'hFF, 1'b1, -1, -1, 80, t1);
    idle(16);
    check("b2b_dv_count", dv_cyc_q.size() - mdv, 2);
    check("b2b_byte0", dvb(mdv), 8'h00);
    check("b2b_byte1", dvb(mdv + 1), 8'hFF);
    check("b2b_spacing", dvc(mdv + 1) - dvc(mdv), 80);
    check("b2b_err_count", err_cyc_q.size() - merr, 0);

    mdv = dv_cyc_q.size();
    merr = err_cyc_q.size();
    mr = rise_q.size();
    send(8'h00, 1'b0, -1, -1, 2, t0);
    idle(20);
    check("glitch_rise_count", rise_q.size() - mr, 1);
    check("glitch_rise_edge", (rise_q.size() > mr) ? rise_q[mr] - t0 : -1, 3);
    check("glitch_active_len", (rise_q.size() > mr) ? fall_cyc - rise_q[mr] : -1, 4);
    check("glitch_no_dv", dv_cyc_q.size() - mdv, 0);
    check("glitch_no_err", err_cyc_q.size() - merr, 0);
    check("glitch_byte", rx_byte, 8'hFF);

    mdv = dv_cyc_q.size();
    merr = err_cyc_q.size();
    mr = rise_q.size();
    send(8'h3C, 1'b0, -1, -1, 80, t0);
    line = 1'b0;
    repeat (30) @(posedge clk);
    check("stuck_err_count", err_cyc_q.size() - merr, 1);
    check("stuck_err_edge", erc(merr) - t0, 79);
    check("stuck_no_dv", dv_cyc_q.size() - mdv, 0);
    check("stuck_byte", rx_byte, 8'hFF);
    check("stuck_no_retrigger", rise_q.size() - mr, 1);
    line = 1'b1;
    @(posedge clk);
    send(8'h81, 1'b1, -1, -1, 80, t0);
    idle(16);
    check("after_break_dv_count", dv_cyc_q.size() - mdv, 1);
    check("after_break_byte", dvb(mdv), 8'h81);
    check("after_break_edge", dvc(mdv) - t0, 79);

    mdv = dv_cyc_q.size();
    merr = err_cyc_q.size();
    send(8'h5A, 1'b1, -1, 43, 44, t0);
    check("midrst_byte", rx_byte, 0);
    check("midrst_dv", dv, 0);
    check("midrst_active", active, 0);
    check("midrst_err", err, 0);
    idle(100);
    check("midrst_no_dv", dv_cyc_q.size() - mdv, 0);
    check("midrst_no_err", err_cyc_q.size() - merr, 0);
    send(8'h5A, 1'b1, -1, -1, 80, t0);
    idle(16);
    check("postrst_dv_count", dv_cyc_q.size() - mdv, 1);
    check("postrst_byte", rx_byte, 8'h5A);

`ifdef UART_RX_MAJORITY_EN
    exp_maj = 8'hF0;
`else
    exp_maj = 8'hF1;
`endif
    send(8'hF0, 1'b1, 12, -1, 80, t0);
    idle(16);
    check("glitch_last_sample_byte", rx_byte, exp_maj);
    send(8'hF0, 1'b1, 11, -1, 80, t0);
    idle(16);
    check("glitch_mid_sample_byte", rx_byte, 8'hF0);

    check("dv_err_overlap", overlap, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
